// File: rtl/axi_vdma_write_burst_gen_pkg.sv
// axi_vdma_pkg: definitions shared by the VDMA burst request generators.
//   wburst_state_t      - burst generator FSM states
//   AXI_4K_BYTES        - AXI burst boundary size in bytes
//   DEFAULT_BEAT_BYTES  - default bytes per data beat (AxSIZE 3'b101)
//   burst_len_f         - min(remaining, max_burst, beats left before 4 KB)
package axi_vdma_pkg;

  typedef enum logic [2:0] {
    WB_IDLE,
    WB_CALC,
    WB_WAIT_DATA,
    WB_REQ,
    WB_WAIT_DONE,
    WB_FRAME_DONE
  } wburst_state_t;

  localparam int unsigned AXI_4K_BYTES       = 4096;
  localparam int unsigned DEFAULT_BEAT_BYTES = 32;

  // Length of the next burst. The caller clamps 'remaining' to 13 bits
  // (anything above 4096 beats is longer than any legal burst anyway).
  // addr_lo must already be beat-aligned, so the result is never 0.
  function automatic logic [12:0] burst_len_f(
    input logic [12:0]  remaining,
    input logic [12:0]  max_burst,
    input logic [11:0]  addr_lo,
    input int unsigned  beat_shift
  );
    logic [12:0] to_4k;
    logic [12:0] len;
    to_4k = (13'(AXI_4K_BYTES) - {1'b0, addr_lo}) >> beat_shift;
    len   = remaining;
    if (max_burst < len) len = max_burst;
    if (to_4k < len)     len = to_4k;
    return len;
  endfunction

endpackage

// File: rtl/axi_vdma_write_burst_gen_if.sv
// Burst request handshake between the write burst generator and the
// AXI write state core.
//   write_req - burst request (generator -> core)
//   req_len   - burst length in beats (generator -> core)
//   req_addr  - burst start byte address (generator -> core)
//   req_resp  - core accepted the request (core -> generator)
//   req_done  - core received the B response (core -> generator)
interface axi_vdma_write_burst_gen_if #(
  parameter int LSIZE = 10,
  parameter int ASIZE = 32
) ();

  logic             write_req;
  logic [LSIZE-1:0] req_len;
  logic [ASIZE-1:0] req_addr;
  logic             req_resp;
  logic             req_done;

  modport master (
    output write_req, req_len, req_addr,
    input  req_resp, req_done
  );

  modport slave (
    input  write_req, req_len, req_addr,
    output req_resp, req_done
  );

endinterface

// File: rtl/axi_vdma_write_burst_gen.sv
// Write-path burst request generator for the VDMA.
// Splits one frame-store transfer (base address + beat count) into AXI
// bursts capped at MAX_BURST beats that never cross a 4 KB boundary, and
// issues each burst only once the write data FIFO holds all of its beats.
// Ports:
//   axi_aclk, axi_resetn - clock, asynchronous active-low reset
//   frame_start          - one-cycle pulse starting a transfer (IDLE only)
//   base_addr            - start byte address, sampled on frame_start
//   total_beats          - beats to write, sampled on frame_start
//   fifo_count           - beats currently held in the write data FIFO
//   req_bus              - write_req/req_len/req_addr/req_resp/req_done
//   busy                 - transfer in progress
//   frame_done           - one-cycle pulse at the end of the transfer
module axi_vdma_write_burst_gen
  import axi_vdma_pkg::*;
#(
  parameter int LSIZE      = 10,
  parameter int ASIZE      = 32,
  parameter int CSIZE      = 24,
  parameter int FSIZE      = 11,
  parameter int MAX_BURST  = 256,
  parameter int BEAT_BYTES = DEFAULT_BEAT_BYTES
) (
  input  logic                        axi_aclk,
  input  logic                        axi_resetn,
  input  logic                        frame_start,
  input  logic [ASIZE-1:0]            base_addr,
  input  logic [CSIZE-1:0]            total_beats,
  input  logic [FSIZE-1:0]            fifo_count,
  axi_vdma_write_burst_gen_if.master  req_bus,
  output logic                        busy,
  output logic                        frame_done
);

  localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);

  wburst_state_t    cstate;
  logic [ASIZE-1:0] addr_q;
  logic [CSIZE-1:0] remaining_q;
  logic [LSIZE-1:0] len_q;
  logic             write_req_q;
  logic             busy_q;
  logic             frame_done_q;

  logic [12:0]      rem_clamp;
  logic [12:0]      calc_len;

  always_comb begin
    rem_clamp = 13'(remaining_q);
    if (32'(remaining_q) > 32'(AXI_4K_BYTES)) rem_clamp = 13'(AXI_4K_BYTES);
    calc_len = burst_len_f(rem_clamp, 13'(MAX_BURST), addr_q[11:0], BEAT_SHIFT);
  end

  // req_addr is the running address register itself; it only advances on
  // the WAIT_DONE exit, so it is stable for the whole request/response.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      cstate       <= WB_IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      len_q        <= '0;
      write_req_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (cstate)
        WB_IDLE: begin
          if (frame_start) begin
            addr_q      <= base_addr & ~ASIZE'(BEAT_BYTES - 1);
            remaining_q <= total_beats;
            busy_q      <= 1'b1;
            cstate      <= (total_beats == '0) ? WB_FRAME_DONE : WB_CALC;
          end
        end
        WB_CALC: begin
          len_q  <= LSIZE'(calc_len);
          cstate <= WB_WAIT_DATA;
        end
        WB_WAIT_DATA: begin
          if (32'(fifo_count) >= 32'(len_q)) begin
            write_req_q <= 1'b1;
            cstate      <= WB_REQ;
          end
        end
        WB_REQ: begin
          if (req_bus.req_resp) begin
            write_req_q <= 1'b0;
            cstate      <= WB_WAIT_DONE;
          end
        end
        WB_WAIT_DONE: begin
          if (req_bus.req_done) begin
            addr_q      <= addr_q + (ASIZE'(len_q) << BEAT_SHIFT);
            remaining_q <= remaining_q - CSIZE'(len_q);
            cstate      <= (remaining_q == CSIZE'(len_q)) ? WB_FRAME_DONE : WB_CALC;
          end
        end
        WB_FRAME_DONE: begin
          frame_done_q <= 1'b1;
          busy_q       <= 1'b0;
          cstate       <= WB_IDLE;
        end
        default: cstate <= WB_IDLE;
      endcase
    end
  end

  assign req_bus.write_req = write_req_q;
  assign req_bus.req_len   = len_q;
  assign req_bus.req_addr  = addr_q;
  assign busy              = busy_q;
  assign frame_done        = frame_done_q;

endmodule

// File: tb/tb_axi_vdma_write_burst_gen.sv
// Self-checking bench for axi_vdma_write_burst_gen: table-driven frames,
// hand-written corner sequences and randomized frames against a burst-list
// reference model.
module tb_axi_vdma_write_burst_gen;

  logic        axi_aclk    = 1'b0;
  logic        axi_resetn  = 1'b0;
  logic        frame_start = 1'b0;
  logic [31:0] base_addr   = '0;
  logic [23:0] total_beats = '0;
  logic [10:0] fifo_count  = '0;
  logic        busy;
  logic        frame_done;

  axi_vdma_write_burst_gen_if #(.LSIZE(10), .ASIZE(32)) bus ();

  axi_vdma_write_burst_gen #(
    .LSIZE(10), .ASIZE(32), .CSIZE(24), .FSIZE(11), .MAX_BURST(256), .BEAT_BYTES(32)
  ) dut (
    .axi_aclk   (axi_aclk),
    .axi_resetn (axi_resetn),
    .frame_start(frame_start),
    .base_addr  (base_addr),
    .total_beats(total_beats),
    .fifo_count (fifo_count),
    .req_bus    (bus),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 axi_aclk = ~axi_aclk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0]      base;
    logic [23:0]      total;
    logic             inject;
    logic [1:0]       n;
    logic [2:0][31:0] a;
    logic [2:0][9:0]  l;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] base, input logic [23:0] total,
                              input logic inject, input logic [1:0] n,
                              input logic [31:0] a0, input logic [9:0] l0,
                              input logic [31:0] a1, input logic [9:0] l1,
                              input logic [31:0] a2, input logic [9:0] l2);
    vec_t v;
    v.base = base; v.total = total; v.inject = inject; v.n = n;
    v.a[0] = a0; v.l[0] = l0;
    v.a[1] = a1; v.l[1] = l1;
    v.a[2] = a2; v.l[2] = l2;
    return v;
  endfunction

  vec_t vecs[7];

  int unsigned exp_a[$];
  int unsigned exp_l[$];
  int unsigned obs_a[$];
  int unsigned obs_l[$];

  // Reference: walk the frame in plain arithmetic, one burst at a time.
  function automatic void model(input logic [31:0] base, input int unsigned total);
    logic [31:0] a;
    int unsigned r, l, to4k;
    exp_a.delete();
    exp_l.delete();
    a = base & 32'hFFFF_FFE0;
    r = total;
    while (r > 0) begin
      to4k = (32'd4096 - (a % 32'd4096)) / 32'd32;
      l = r;
      if (l > 256)  l = 256;
      if (l > to4k) l = to4k;
      exp_a.push_back(a);
      exp_l.push_back(l);
      a = a + l * 32'd32;
      r = r - l;
    end
  endfunction

  task automatic compare_bursts(input string tag);
    check({tag, ".count"}, 64'(obs_a.size()), 64'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
      check($sformatf("%s.addr%0d", tag, i), 64'(obs_a[i]), 64'(exp_a[i]));
      check($sformatf("%s.len%0d", tag, i), 64'(obs_l[i]), 64'(exp_l[i]));
    end
  endtask

  // Drives one frame and plays the write state core. Collects issued bursts.
  task automatic run_frame(input logic [31:0] base, input int unsigned total,
                           input bit fifo_full, input bit inject,
                           output int first_lat, output bit gap_ok,
                           output bit proto_ok, output bit done_ok);
    int          phase, dly, cyc, last_done;
    bit          injected, prev_req;
    logic [31:0] cur_a;
    logic [9:0]  cur_l;
    phase = 0; dly = 0; cyc = 0; last_done = -1;
    injected = 0; prev_req = 0; cur_a = '0; cur_l = '0;
    obs_a.delete();
    obs_l.delete();
    first_lat = -1; gap_ok = 1; proto_ok = 1; done_ok = 0;
    @(negedge axi_aclk);
    frame_start  = 1'b1;
    base_addr    = base;
    total_beats  = 24'(total);
    fifo_count   = fifo_full ? 11'd1023 : 11'($urandom_range(0, 1023));
    bus.req_resp = 1'b0;
    bus.req_done = 1'b0;
    while (cyc < 3000) begin
      @(negedge axi_aclk);
      cyc++;
      frame_start = 1'b0;
      if (bus.write_req && !prev_req) begin
        obs_a.push_back(32'(bus.req_addr));
        obs_l.push_back(32'(bus.req_len));
        cur_a = bus.req_addr;
        cur_l = bus.req_len;
        if (first_lat < 0) first_lat = cyc;
        if (32'(fifo_count) < 32'(bus.req_len)) proto_ok = 0;
        if (fifo_full && last_done >= 0 && (cyc - last_done) != 3) gap_ok = 0;
      end
      if (phase != 0 && (bus.req_addr !== cur_a || bus.req_len !== cur_l)) proto_ok = 0;
      if (phase == 2 && bus.write_req) proto_ok = 0;
      if (frame_done) begin
        done_ok = (busy === 1'b0) && (phase == 0) && !bus.write_req;
        break;
      end
      if (busy !== 1'b1) proto_ok = 0;
      prev_req = bus.write_req;
      bus.req_resp = 1'b0;
      bus.req_done = 1'b0;
      if (!fifo_full) fifo_count = 11'($urandom_range(0, 1023));
      if (phase == 0 && bus.write_req) begin
        phase = 1;
        dly   = $urandom_range(0, 2);
      end
      if (phase == 1) begin
        if (dly == 0) begin
          bus.req_resp = 1'b1;
          phase = 2;
          dly   = $urandom_range(1, 4);
        end else dly--;
      end else if (phase == 2) begin
        if (dly == 0) begin
          bus.req_done = 1'b1;
          phase     = 0;
          last_done = cyc;
        end else begin
          dly--;
          if (inject && !injected) begin
            frame_start = 1'b1;
            base_addr   = 32'h5000_0000;
            total_beats = 24'd7;
            injected    = 1;
          end
        end
      end
    end
    if (done_ok) begin
      @(negedge axi_aclk);
      if (frame_done !== 1'b0) done_ok = 0;
    end
  endtask

  initial begin
    int  lat;
    bit  gap_ok, proto_ok, done_ok, flag;
    int  cnt;
    logic [31:0] rb;

    vecs[0] = mk(32'h1000_0000, 24'd300, 1'b0, 2'd3, 32'h1000_0000, 10'd128,
                 32'h1000_1000, 10'd128, 32'h1000_2000, 10'd44);
    vecs[1] = mk(32'h1000_0F80, 24'd10, 1'b0, 2'd2, 32'h1000_0F80, 10'd4,
                 32'h1000_1000, 10'd6, 32'h0, 10'd0);
    vecs[2] = mk(32'h2000_0000, 24'd16, 1'b0, 2'd1, 32'h2000_0000, 10'd16,
                 32'h0, 10'd0, 32'h0, 10'd0);
    vecs[3] = mk(32'h2000_0013, 24'd5, 1'b0, 2'd1, 32'h2000_0000, 10'd5,
                 32'h0, 10'd0, 32'h0, 10'd0);
    vecs[4] = mk(32'hFFFF_FFE0, 24'd3, 1'b0, 2'd2, 32'hFFFF_FFE0, 10'd1,
                 32'h0000_0000, 10'd2, 32'h0, 10'd0);
    vecs[5] = mk(32'h1000_0000, 24'd300, 1'b1, 2'd3, 32'h1000_0000, 10'd128,
                 32'h1000_1000, 10'd128, 32'h1000_2000, 10'd44);
    vecs[6] = mk(32'h0000_0FE0, 24'd200, 1'b0, 2'd3, 32'h0000_0FE0, 10'd1,
                 32'h0000_1000, 10'd128, 32'h0000_2000, 10'd71);

    bus.req_resp = 1'b0;
    bus.req_done = 1'b0;

    // Reset state
    repeat (3) @(negedge axi_aclk);
    check("rst.write_req", 64'(bus.write_req), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.frame_done", 64'(frame_done), 64'd0);
    check("rst.req_len", 64'(bus.req_len), 64'd0);
    check("rst.req_addr", 64'(bus.req_addr), 64'd0);
    axi_resetn = 1'b1;
    @(negedge axi_aclk);
    check("rst_rel.busy", 64'(busy), 64'd0);

    // Table-driven frames, FIFO always full enough
    foreach (vecs[k]) begin
      run_frame(vecs[k].base, 32'(vecs[k].total), 1'b1, vecs[k].inject,
                lat, gap_ok, proto_ok, done_ok);
      exp_a.delete();
      exp_l.delete();
      for (int i = 0; i < int'(vecs[k].n); i++) begin
        exp_a.push_back(32'(vecs[k].a[i]));
        exp_l.push_back(32'(vecs[k].l[i]));
      end
      compare_bursts($sformatf("vec%0d", k));
      check($sformatf("vec%0d.first_lat", k), 64'(lat), 64'd3);
      check($sformatf("vec%0d.gap3", k), 64'(gap_ok), 64'd1);
      check($sformatf("vec%0d.protocol", k), 64'(proto_ok), 64'd1);
      check($sformatf("vec%0d.frame_done", k), 64'(done_ok), 64'd1);
    end

    // Zero-length frame
    @(negedge axi_aclk);
    frame_start = 1'b1; base_addr = 32'h1234_5678; total_beats = '0;
    @(negedge axi_aclk);
    frame_start = 1'b0;
    check("zero.busy1", 64'(busy), 64'd1);
    check("zero.done_early", 64'(frame_done), 64'd0);
    @(negedge axi_aclk);
    check("zero.frame_done", 64'(frame_done), 64'd1);
    check("zero.busy_fall", 64'(busy), 64'd0);
    check("zero.write_req", 64'(bus.write_req), 64'd0);
    @(negedge axi_aclk);
    check("zero.done_pulse", 64'(frame_done), 64'd0);

    // FIFO gating: 127 beats never releases a 128-beat burst
    frame_start = 1'b1; base_addr = 32'h3000_0000; total_beats = 24'd128; fifo_count = '0;
    flag = 0;
    for (int i = 0; i < 137; i++) begin
      @(negedge axi_aclk);
      frame_start = 1'b0;
      if (bus.write_req) flag = 1;
      if (fifo_count < 11'd127) fifo_count = fifo_count + 11'd1;
    end
    check("gate.no_req_at_127", 64'(flag), 64'd0);
    fifo_count = 11'd128;
    @(negedge axi_aclk);
    check("gate.req_at_128", 64'(bus.write_req), 64'd1);
    check("gate.len", 64'(bus.req_len), 64'd128);
    check("gate.addr", 64'(bus.req_addr), 64'h3000_0000);
    bus.req_resp = 1'b1;
    @(negedge axi_aclk);
    bus.req_resp = 1'b0;
    check("gate.req_drop", 64'(bus.write_req), 64'd0);
    bus.req_done = 1'b1;
    @(negedge axi_aclk);
    bus.req_done = 1'b0;
    check("gate.busy_last", 64'(busy), 64'd1);
    @(negedge axi_aclk);
    check("gate.frame_done", 64'(frame_done), 64'd1);

    // Reset while waiting for the B response
    fifo_count = 11'd1023;
    @(negedge axi_aclk);
    frame_start = 1'b1; base_addr = 32'h1000_0000; total_beats = 24'd300;
    cnt = 0;
    do begin
      @(negedge axi_aclk);
      frame_start = 1'b0;
      cnt++;
    end while (!bus.write_req && cnt < 50);
    check("rstmid.req_seen", 64'(bus.write_req), 64'd1);
    bus.req_resp = 1'b1;
    @(negedge axi_aclk);
    bus.req_resp = 1'b0;
    axi_resetn = 1'b0;
    #1;
    check("rstmid.write_req", 64'(bus.write_req), 64'd0);
    check("rstmid.busy", 64'(busy), 64'd0);
    check("rstmid.frame_done", 64'(frame_done), 64'd0);
    check("rstmid.req_len", 64'(bus.req_len), 64'd0);
    check("rstmid.req_addr", 64'(bus.req_addr), 64'd0);
    @(negedge axi_aclk);
    @(negedge axi_aclk);
    axi_resetn = 1'b1;
    run_frame(32'h2000_0000, 16, 1'b1, 1'b0, lat, gap_ok, proto_ok, done_ok);
    exp_a.delete(); exp_l.delete();
    exp_a.push_back(32'h2000_0000); exp_l.push_back(16);
    compare_bursts("post_rst");
    check("post_rst.frame_done", 64'(done_ok), 64'd1);

    // Randomized frames with a jittery FIFO
    for (int t = 0; t < 30; t++) begin
      int unsigned tot;
      rb = $urandom;
      if (t % 2 == 0) rb[11:0] = 12'($urandom_range(12'hF00, 12'hFFF));
      tot = (t % 7 == 3) ? 0 : $urandom_range(1, 700);
      run_frame(rb, tot, 1'b0, 1'b0, lat, gap_ok, proto_ok, done_ok);
      model(rb, tot);
      compare_bursts($sformatf("rnd%0d", t));
      check($sformatf("rnd%0d.protocol", t), 64'(proto_ok), 64'd1);
      check($sformatf("rnd%0d.frame_done", t), 64'(done_ok), 64'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_vdma_write_burst_gen.md
# axi_vdma_write_burst_gen

Upstream request generator for the AXI write path of the VDMA. It splits one frame-store transfer (base address plus total beat count) into AXI-legal bursts. Each burst is capped at `MAX_BURST` and never crosses a 4 KB boundary. The block issues each burst only when the write data FIFO already holds the whole burst. It drives the `write_req`/`req_len`/`req_addr` handshake of `axi_inf_write_state_core` and waits for that core's `req_resp`/`req_done` before issuing the next burst.

## Interface
Parameters:
- `LSIZE`, 10, width of `req_len`; must hold `MAX_BURST`.
- `ASIZE`, 32, address width.
- `CSIZE`, 24, width of the frame beat count.
- `FSIZE`, 11, width of the FIFO occupancy count.
- `MAX_BURST`, 256, maximum beats per burst; range 1..256.
- `BEAT_BYTES`, 32, bytes per beat; power of two; matches AxSIZE 3'b101.

Ports:
- `axi_aclk`  in  1  clock.
- `axi_resetn`  in  1  reset; asynchronous, active-low.
- `frame_start`  in  1  one-cycle pulse that starts a transfer.
- `base_addr`  in  ASIZE  start byte address; sampled on `frame_start`.
- `total_beats`  in  CSIZE  beats to write; sampled on `frame_start`.
- `fifo_count`  in  FSIZE  beats currently in the write data FIFO.
- `write_req`  out  1  burst request to the write state core.
- `req_len`  out  LSIZE  burst length in beats (1..MAX_BURST).
- `req_addr`  out  ASIZE  burst start address.
- `req_resp`  in  1  core accepted the request.
- `req_done`  in  1  core received the B response.
- `busy`  out  1  high from frame acceptance until `frame_done`.
- `frame_done`  out  1  one-cycle pulse at the end of the transfer.

## Operation
- FSM states: IDLE, CALC, WAIT_DATA, REQ, WAIT_DONE, FRAME_DONE.
- IDLE: on `frame_start`, latch `addr = base_addr` with the low log2(BEAT_BYTES) bits forced to 0, and latch `remaining = total_beats`.
  - If `total_beats == 0`, go to FRAME_DONE.
  - Otherwise go to CALC.
  - `frame_start` outside IDLE is ignored.
- CALC: register `len = min(remaining, MAX_BURST, beats_to_4k)`, where `beats_to_4k = (4096 - addr[11:0]) / BEAT_BYTES`.
  - Compute at 13 bits; the result is always ≥ 1.
  - Go to WAIT_DATA.
- WAIT_DATA: when `fifo_count >= len` (unsigned), go to REQ.
- REQ: hold `write_req` high until `req_resp` is sampled high, then go to WAIT_DONE.
- WAIT_DONE: on `req_done`, update `addr += len*BEAT_BYTES` (wraps modulo 2^ASIZE) and `remaining -= len`.
  - If the new `remaining == 0`, go to FRAME_DONE; otherwise go to CALC.
- FRAME_DONE: pulse `frame_done`, then go to IDLE.
- `req_done` or `req_resp` outside REQ/WAIT_DONE is ignored.

## Timing
- Reset (asynchronous assert, release synchronous to `axi_aclk`):
  - State = IDLE.
  - `write_req`, `busy`, `frame_done` = 0.
  - `req_len`, `req_addr`, and the internal counters = 0.
- All outputs are registered. `write_req` is high exactly while cstate == REQ.
- `req_len` and `req_addr` are stable from the cycle before `write_req` rises until WAIT_DONE exits. The core re-registers `awlen` every cycle, so they must not change in between.
- Latency:
  - `frame_start` → first `write_req`: 3 cycles minimum (IDLE→CALC→WAIT_DATA→REQ) when the FIFO is already full enough.
  - `req_done` → next `write_req`: 3 cycles minimum.
  - `frame_start` with zero beats → `frame_done`: 2 cycles.
- `busy` rises the cycle after `frame_start` is accepted and falls in the same cycle `frame_done` pulses.
- If `req_resp` arrives in the same cycle `write_req` rises, it is accepted.
- If `req_resp` and `req_done` arrive together, `req_done` is ignored. The core never does this.
- Reset mid-burst abandons the transfer with no `frame_done`. The write state core must be reset in the same cycle.

## Structure
- Shared package `axi_vdma_pkg` holds:
  - the burst FSM state enum `wburst_state_t`;
  - `AXI_4K_BYTES = 4096`;
  - the default `BEAT_BYTES`.
- The min-of-three length computation is a combinational function in the package, `burst_len_f`. It is reused by the future read-side generator.
- Single module; no sub-module instance.

## Test plan
- Boundary splitting: base 0x1000_0000, total 300, FIFO count held at 1023 → bursts (0x1000_0000, 128), (0x1000_1000, 128), (0x1000_2000, 44); one `frame_done`.
- Unaligned start: base 0x1000_0F80, total 10 → bursts (0x1000_0F80, 4), (0x1000_1000, 6).
- FIFO gating: total 128, FIFO count ramps 0→127 and holds → `write_req` stays 0. Raise the count to 128 → `write_req` rises 1 cycle later.
- Zero length: total 0 → `frame_done` 2 cycles after `frame_start`; no `write_req`; `busy` high for 1 cycle.
- `frame_start` pulsed during WAIT_DONE → ignored; the original address and length sequence is unchanged.
- Reset asserted in WAIT_DONE → all outputs 0 immediately. A later frame (base 0x2000_0000, total 16) issues a single burst (0x2000_0000, 16).
